decoder3x8_seq: RTL

Sequenced 3-to-8 decoder: the receive-side counterpart of the 8x3 encoder. It accepts 3-bit codes over a valid/ready handshake and buffers them in a 2-entry FIFO. Each code is replayed as a one-hot byte held for a fixed number of cycles, followed by an optional all-zero gap. It drives one-hot select/strobe lines from a code stream, e.g. lamp/segment scanning.

---
 rtl/decoder3x8_seq.sv | 97 +++++++++
 1 files changed

// File: rtl/decoder3x8_seq.sv
// decoder3x8_seq: buffers 3-bit codes in a 2-entry FIFO and replays each as a one-hot byte for HOLD cycles plus GAP zero cycles
//   in_valid/in_ready/code : code input handshake, ready only from registered occupancy
//   data                   : registered one-hot word or zero
//   done                   : high on the last cycle a word is driven
//   busy                   : FSM active or FIFO non-empty
//   count                  : codes popped since reset, wrapping
module decoder3x8_seq #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  code,
    output logic [7:0]  data,
    output logic        done,
    output logic        busy,
    output logic [15:0] count
);
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  mem_q [2];
    logic [2:0]  mem_d [2];
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [1:0]  occ_q, occ_d;
    logic        push, pop;
    assign in_ready = occ_q != 2'd2;
    assign done     = state_q == S_HOLD && cnt_q == 8'd0;
    assign busy     = state_q != S_IDLE || occ_q != 2'd0;
    assign data     = data_q;
    assign count    = count_q;
    always_comb begin
        push    = in_valid && in_ready;
        pop     = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: pop = occ_q != 2'd0;
            S_HOLD:
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                else if (GAP > 0) begin
                    data_d  = 8'd0;
                    cnt_d   = 8'(GAP - 1);
                    state_d = S_GAP;
                end
                else if (occ_q != 2'd0) pop = 1'b1;
                else begin
                    data_d  = 8'd0;
                    state_d = S_IDLE;
                end
            S_GAP:
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                else if (occ_q != 2'd0) pop = 1'b1;
                else state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // a pop always restarts a word, whatever state it came from
        if (pop) begin
            data_d  = 8'd1 << mem_q[rd_q];
            cnt_d   = 8'(HOLD - 1);
            state_d = S_HOLD;
            count_d = count_q + 16'd1;
        end
        mem_d = mem_q;
        if (push) mem_d[wr_q] = code;
        wr_d  = wr_q ^ push;
        rd_d  = rd_q ^ pop;
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            data_q  <= 8'd0;
            count_q <= 16'd0;
            mem_q   <= '{default: '0};
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
        end
    end
endmodule
